// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle control sequencer: FSM states, RV32I opcodes,
// immediate/ALU/write-back select codes and the decoded control bundle.
package mc_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_e;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   // Immediate-format codes, identical to the immgen select encoding
   localparam logic [2:0] IMM_R = 3'b000;
   localparam logic [2:0] IMM_I = 3'b001;
   localparam logic [2:0] IMM_S = 3'b010;
   localparam logic [2:0] IMM_B = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;
   localparam logic [2:0] IMM_U = 3'b101;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_COPYB = 4'd10;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic       legal;
      logic [2:0] immsel;
      logic [3:0] alu_op;
      logic       opa_sel;
      logic       opb_sel;
      logic       br_un;
      logic [1:0] wb_sel;
      logic       is_load;
      logic       is_store;
      logic       is_branch;
      logic       is_jump;
      logic       is_jalr;
      logic       rd_nz;
   } ctrl_t;

   // R-type and I-type share the funct3 mapping; alt selects SUB/SRA
   function automatic logic [3:0] alu_from_funct(input logic [2:0] funct3, input logic alt);
      logic [3:0] op;
      case (funct3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   function automatic logic branch_taken(input logic [2:0] funct3, input logic eq, input logic lt);
      logic t;
      case (funct3)
         3'b000:          t = eq;
         3'b001:          t = !eq;
         3'b100, 3'b110:  t = lt;
         3'b101, 3'b111:  t = !lt;
         default:         t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational decode of the latched instruction register into datapath control fields.
module mc_decode
   import mc_pkg::*;
(
   input  logic [31:0] inst,
   output ctrl_t       ctrl
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       unused_bits;

   assign opcode      = inst[6:0];
   assign funct3      = inst[14:12];
   assign unused_bits = ^{inst[31], inst[29:15]};

   always_comb begin
      ctrl           = '0;
      ctrl.immsel    = IMM_R;
      ctrl.alu_op    = ALU_ADD;
      ctrl.wb_sel    = WB_ALU;
      ctrl.rd_nz     = (inst[11:7] != 5'd0);
      case (opcode)
         OP_REG: begin
            ctrl.legal  = 1'b1;
            ctrl.alu_op = alu_from_funct(funct3, inst[30]);
         end
         OP_IMM: begin
            ctrl.legal   = 1'b1;
            ctrl.immsel  = IMM_I;
            ctrl.opb_sel = 1'b1;
            // bit 30 is part of the immediate except for the shift-right forms
            ctrl.alu_op  = alu_from_funct(funct3, (funct3 == 3'b101) && inst[30]);
         end
         OP_LUI: begin
            ctrl.legal   = 1'b1;
            ctrl.immsel  = IMM_U;
            ctrl.opb_sel = 1'b1;
            ctrl.alu_op  = ALU_COPYB;
         end
         OP_AUIPC: begin
            ctrl.legal   = 1'b1;
            ctrl.immsel  = IMM_U;
            ctrl.opa_sel = 1'b1;
            ctrl.opb_sel = 1'b1;
         end
         OP_JAL: begin
            ctrl.legal   = 1'b1;
            ctrl.immsel  = IMM_J;
            ctrl.opa_sel = 1'b1;
            ctrl.opb_sel = 1'b1;
            ctrl.wb_sel  = WB_PC4;
            ctrl.is_jump = 1'b1;
         end
         OP_JALR: begin
            ctrl.legal   = 1'b1;
            ctrl.immsel  = IMM_I;
            ctrl.opb_sel = 1'b1;
            ctrl.wb_sel  = WB_PC4;
            ctrl.is_jump = 1'b1;
            ctrl.is_jalr = 1'b1;
         end
         OP_BRANCH: begin
            ctrl.legal     = (funct3 != 3'b010) && (funct3 != 3'b011);
            ctrl.immsel    = IMM_B;
            ctrl.opa_sel   = 1'b1;
            ctrl.opb_sel   = 1'b1;
            ctrl.br_un     = funct3[1];
            ctrl.is_branch = 1'b1;
         end
         OP_LOAD: begin
            ctrl.legal   = 1'b1;
            ctrl.immsel  = IMM_I;
            ctrl.opb_sel = 1'b1;
            ctrl.wb_sel  = WB_LOAD;
            ctrl.is_load = 1'b1;
         end
         OP_STORE: begin
            ctrl.legal    = 1'b1;
            ctrl.immsel   = IMM_S;
            ctrl.opb_sel  = 1'b1;
            ctrl.is_store = 1'b1;
         end
         default: ctrl.legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control sequencer: owns the FETCH/DECODE/EXEC/MEM/WB/TRAP FSM,
// the program counter and the instruction register.
module mc_ctrl
   import mc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_imem_ack,
   input  logic        i_dmem_ack,
   input  logic        i_br_equal,
   input  logic        i_br_less,
   input  logic [31:0] i_alu_res,
   output logic        o_imem_req,
   output logic [31:0] o_pc,
   output logic [31:0] o_inst,
   output logic [2:0]  o_immsel,
   output logic [3:0]  o_alu_op,
   output logic        o_opa_sel,
   output logic        o_opb_sel,
   output logic        o_br_un,
   output logic        o_dmem_req,
   output logic        o_dmem_wren,
   output logic [1:0]  o_wb_sel,
   output logic        o_rd_wren,
   output logic        o_illegal
);

   state_e      state, state_next;
   logic [31:0] pc, pc_next, pc_plus4;
   logic [31:0] ir, ir_next;
   logic        illegal, illegal_next;
   logic        taken;
   logic        ctrl_window;
   ctrl_t       ctrl;

   mc_decode u_decode (
      .inst (ir),
      .ctrl (ctrl)
   );

   assign pc_plus4 = pc + 32'd4;
   assign taken    = branch_taken(ir[14:12], i_br_equal, i_br_less);

   always_comb begin
      state_next   = state;
      pc_next      = pc;
      ir_next      = ir;
      illegal_next = illegal;
      case (state)
         ST_FETCH: begin
            if (i_imem_ack) begin
               ir_next    = i_imem_rdata;
               state_next = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (ctrl.legal) begin
               state_next = ST_EXEC;
            end else begin
               state_next   = ST_TRAP;
               illegal_next = 1'b1;
            end
         end
         ST_EXEC: begin
            if (ctrl.is_branch) begin
               pc_next    = taken ? i_alu_res : pc_plus4;
               state_next = ST_FETCH;
            end else if (ctrl.is_load || ctrl.is_store) begin
               state_next = ST_MEM;
            end else begin
               state_next = ST_WB;
            end
         end
         ST_MEM: begin
            if (i_dmem_ack) begin
               if (ctrl.is_store) begin
                  pc_next    = pc_plus4;
                  state_next = ST_FETCH;
               end else begin
                  state_next = ST_WB;
               end
            end
         end
         ST_WB: begin
            // JALR targets are forced to halfword alignment by clearing bit 0
            if (ctrl.is_jump) begin
               pc_next = ctrl.is_jalr ? {i_alu_res[31:1], 1'b0} : i_alu_res;
            end else begin
               pc_next = pc_plus4;
            end
            state_next = ST_FETCH;
         end
         ST_TRAP: begin
            illegal_next = 1'b1;
         end
         default: begin
            state_next   = ST_TRAP;
            illegal_next = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= ST_FETCH;
         pc      <= RESET_PC;
         ir      <= NOP_INST;
         illegal <= 1'b0;
      end else begin
         state   <= state_next;
         pc      <= pc_next;
         ir      <= ir_next;
         illegal <= illegal_next;
      end
   end

   assign ctrl_window = (state == ST_EXEC) || (state == ST_MEM) || (state == ST_WB);

   always_comb begin
      o_pc        = pc;
      o_inst      = ir;
      o_illegal   = illegal;
      o_immsel    = IMM_R;
      o_alu_op    = ALU_ADD;
      o_opa_sel   = 1'b0;
      o_opb_sel   = 1'b0;
      o_br_un     = 1'b0;
      o_wb_sel    = WB_ALU;
      if (ctrl_window) begin
         o_immsel  = ctrl.immsel;
         o_alu_op  = ctrl.alu_op;
         o_opa_sel = ctrl.opa_sel;
         o_opb_sel = ctrl.opb_sel;
         o_br_un   = ctrl.br_un;
         o_wb_sel  = ctrl.wb_sel;
      end
      // requests and strobes are forced low for the whole reset cycle
      o_imem_req  = !i_rst && (state == ST_FETCH);
      o_dmem_req  = !i_rst && (state == ST_MEM);
      o_dmem_wren = !i_rst && (state == ST_MEM) && ctrl.is_store;
      o_rd_wren   = !i_rst && (state == ST_WB) && ctrl.rd_nz;
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: each task drives one scenario and checks hand-computed values.
module tb_mc_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [31:0] i_imem_rdata = 32'h0;
   logic        i_imem_ack = 1'b0;
   logic        i_dmem_ack = 1'b0;
   logic        i_br_equal = 1'b0;
   logic        i_br_less = 1'b0;
   logic [31:0] i_alu_res = 32'h0;
   logic        o_imem_req;
   logic [31:0] o_pc;
   logic [31:0] o_inst;
   logic [2:0]  o_immsel;
   logic [3:0]  o_alu_op;
   logic        o_opa_sel;
   logic        o_opb_sel;
   logic        o_br_un;
   logic        o_dmem_req;
   logic        o_dmem_wren;
   logic [1:0]  o_wb_sel;
   logic        o_rd_wren;
   logic        o_illegal;

   int checks = 0;
   int errors = 0;

   always #5 i_clk = ~i_clk;

   mc_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_imem_rdata (i_imem_rdata),
      .i_imem_ack   (i_imem_ack),
      .i_dmem_ack   (i_dmem_ack),
      .i_br_equal   (i_br_equal),
      .i_br_less    (i_br_less),
      .i_alu_res    (i_alu_res),
      .o_imem_req   (o_imem_req),
      .o_pc         (o_pc),
      .o_inst       (o_inst),
      .o_immsel     (o_immsel),
      .o_alu_op     (o_alu_op),
      .o_opa_sel    (o_opa_sel),
      .o_opb_sel    (o_opb_sel),
      .o_br_un      (o_br_un),
      .o_dmem_req   (o_dmem_req),
      .o_dmem_wren  (o_dmem_wren),
      .o_wb_sel     (o_wb_sel),
      .o_rd_wren    (o_rd_wren),
      .o_illegal    (o_illegal)
   );

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Fetch driver: holds ack low for 'waits' cycles, then acks; reports cycles with req high
   task automatic fetch(input logic [31:0] inst, input int waits, output int req_cycles);
      req_cycles = 0;
      for (int w = 0; w < waits; w++) begin
         if (o_imem_req === 1'b1) req_cycles++;
         step();
      end
      i_imem_rdata = inst;
      i_imem_ack   = 1'b1;
      #1;
      if (o_imem_req === 1'b1) req_cycles++;
      step();
      i_imem_ack   = 1'b0;
      i_imem_rdata = 32'hDEAD_BEEF;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      step();
      checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req_low: got %b expected 0", o_imem_req); end
      step();
      checks++; if (o_rd_wren !== 1'b0) begin errors++; $display("FAIL rst_rd_wren_low: got %b expected 0", o_rd_wren); end
      i_rst = 1'b0;
      #1;
      checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 00000000", o_pc); end
      checks++; if (o_imem_req !== 1'b1) begin errors++; $display("FAIL rst_imem_req: got %b expected 1", o_imem_req); end
      checks++; if (o_illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal: got %b expected 0", o_illegal); end
      checks++; if (o_inst !== 32'h0000_0013) begin errors++; $display("FAIL rst_ir_nop: got %h expected 00000013", o_inst); end
   endtask

   task automatic test_addi();
      int n;
      fetch(32'h0050_0093, 3, n);
      checks++; if (n !== 4) begin errors++; $display("FAIL addi_req_held: got %0d expected 4", n); end
      checks++; if (o_inst !== 32'h0050_0093) begin errors++; $display("FAIL addi_ir: got %h expected 00500093", o_inst); end
      checks++; if (o_immsel !== 3'b000) begin errors++; $display("FAIL addi_decode_immsel_idle: got %b expected 000", o_immsel); end
      step();
      checks++; if (o_immsel !== 3'b001) begin errors++; $display("FAIL addi_immsel: got %b expected 001", o_immsel); end
      checks++; if (o_opb_sel !== 1'b1 || o_opa_sel !== 1'b0) begin errors++; $display("FAIL addi_opsel: got a=%b b=%b expected a=0 b=1", o_opa_sel, o_opb_sel); end
      checks++; if (o_alu_op !== 4'd0) begin errors++; $display("FAIL addi_alu_op: got %0d expected 0", o_alu_op); end
      checks++; if (o_rd_wren !== 1'b0) begin errors++; $display("FAIL addi_exec_no_wren: got %b expected 0", o_rd_wren); end
      step();
      checks++; if (o_rd_wren !== 1'b1 || o_wb_sel !== 2'b00) begin errors++; $display("FAIL addi_wb: got wren=%b sel=%b expected wren=1 sel=00", o_rd_wren, o_wb_sel); end
      step();
      checks++; if (o_rd_wren !== 1'b0) begin errors++; $display("FAIL addi_wren_single: got %b expected 0", o_rd_wren); end
      checks++; if (o_pc !== 32'h4 || o_imem_req !== 1'b1) begin errors++; $display("FAIL addi_next_pc: got pc=%h req=%b expected pc=00000004 req=1", o_pc, o_imem_req); end
   endtask

   task automatic test_branches();
      int n;
      // BEQ taken to 8
      fetch(32'h0000_0463, 0, n);
      checks++; if (n !== 1) begin errors++; $display("FAIL beq_req: got %0d expected 1", n); end
      step();
      i_br_equal = 1'b1; i_alu_res = 32'h8;
      #1;
      checks++; if (o_immsel !== 3'b011 || o_opa_sel !== 1'b1 || o_opb_sel !== 1'b1 || o_br_un !== 1'b0) begin errors++; $display("FAIL beq_exec_fields: got imm=%b a=%b b=%b un=%b expected 011 1 1 0", o_immsel, o_opa_sel, o_opb_sel, o_br_un); end
      step();
      checks++; if (o_pc !== 32'h8 || o_imem_req !== 1'b1 || o_rd_wren !== 1'b0) begin errors++; $display("FAIL beq_taken: got pc=%h req=%b wren=%b expected 00000008 1 0", o_pc, o_imem_req, o_rd_wren); end
      // BNE with equal operands falls through to 12
      fetch(32'h0000_1463, 0, n);
      step();
      i_alu_res = 32'h40;
      step();
      checks++; if (o_pc !== 32'hC) begin errors++; $display("FAIL bne_not_taken: got %h expected 0000000c", o_pc); end
      // BLTU taken to 0x100
      fetch(32'h0000_6463, 0, n);
      step();
      i_br_equal = 1'b0; i_br_less = 1'b1; i_alu_res = 32'h100;
      #1;
      checks++; if (o_br_un !== 1'b1) begin errors++; $display("FAIL bltu_br_un: got %b expected 1", o_br_un); end
      step();
      i_br_less = 1'b0;
      checks++; if (o_pc !== 32'h100) begin errors++; $display("FAIL bltu_taken: got %h expected 00000100", o_pc); end
   endtask

   task automatic test_load_store();
      int n, req_n, wren_n, rd_n;
      // LW x2,0(x0) at 0x100, with a stray imem ack during EXEC
      fetch(32'h0000_2103, 1, n);
      checks++; if (n !== 2) begin errors++; $display("FAIL lw_req: got %0d expected 2", n); end
      step();
      checks++; if (o_immsel !== 3'b001) begin errors++; $display("FAIL lw_immsel: got %b expected 001", o_immsel); end
      i_imem_ack = 1'b1; i_imem_rdata = 32'hFFFF_FFFF;
      step();
      i_imem_ack = 1'b0;
      checks++; if (o_inst !== 32'h0000_2103) begin errors++; $display("FAIL stray_imem_ack: got ir=%h expected 00002103", o_inst); end
      req_n = 0; wren_n = 0; rd_n = 0;
      for (int i = 0; i < 5; i++) begin
         if (o_dmem_req === 1'b1) req_n++;
         if (o_dmem_wren === 1'b1) wren_n++;
         if (o_rd_wren === 1'b1) rd_n++;
         step();
      end
      i_dmem_ack = 1'b1;
      #1;
      checks++; if (o_dmem_req !== 1'b1) begin errors++; $display("FAIL lw_req_at_ack: got %b expected 1", o_dmem_req); end
      step();
      i_dmem_ack = 1'b0;
      checks++; if (req_n !== 5 || wren_n !== 0 || rd_n !== 0) begin errors++; $display("FAIL lw_mem_wait: got req=%0d wren=%0d rd=%0d expected 5 0 0", req_n, wren_n, rd_n); end
      checks++; if (o_wb_sel !== 2'b01 || o_rd_wren !== 1'b1) begin errors++; $display("FAIL lw_wb: got sel=%b wren=%b expected 01 1", o_wb_sel, o_rd_wren); end
      step();
      checks++; if (o_pc !== 32'h104) begin errors++; $display("FAIL lw_next_pc: got %h expected 00000104", o_pc); end
      // SW x2,0(x0) at 0x104
      fetch(32'h0020_2023, 0, n);
      step();
      checks++; if (o_immsel !== 3'b010 || o_opb_sel !== 1'b1) begin errors++; $display("FAIL sw_exec: got imm=%b b=%b expected 010 1", o_immsel, o_opb_sel); end
      step();
      req_n = 0; wren_n = 0; rd_n = 0;
      for (int i = 0; i < 5; i++) begin
         if (o_dmem_req === 1'b1) req_n++;
         if (o_dmem_wren === 1'b1) wren_n++;
         if (o_rd_wren === 1'b1) rd_n++;
         step();
      end
      i_dmem_ack = 1'b1;
      step();
      i_dmem_ack = 1'b0;
      checks++; if (req_n !== 5 || wren_n !== 5 || rd_n !== 0) begin errors++; $display("FAIL sw_mem_wait: got req=%0d wren=%0d rd=%0d expected 5 5 0", req_n, wren_n, rd_n); end
      checks++; if (o_pc !== 32'h108 || o_imem_req !== 1'b1 || o_rd_wren !== 1'b0) begin errors++; $display("FAIL sw_next: got pc=%h req=%b wren=%b expected 00000108 1 0", o_pc, o_imem_req, o_rd_wren); end
   endtask

   task automatic test_jumps();
      int n, rd_n;
      // JAL x1 at 0x108 to 0x10
      i_alu_res = 32'h10;
      fetch(32'h0080_00EF, 0, n);
      step();
      checks++; if (o_immsel !== 3'b100 || o_opa_sel !== 1'b1) begin errors++; $display("FAIL jal_exec: got imm=%b a=%b expected 100 1", o_immsel, o_opa_sel); end
      step();
      checks++; if (o_wb_sel !== 2'b10 || o_rd_wren !== 1'b1) begin errors++; $display("FAIL jal_wb: got sel=%b wren=%b expected 10 1", o_wb_sel, o_rd_wren); end
      step();
      checks++; if (o_pc !== 32'h10) begin errors++; $display("FAIL jal_pc: got %h expected 00000010", o_pc); end
      // JALR x1,0(x1) with odd target 0x21 -> 0x20
      i_alu_res = 32'h21;
      fetch(32'h0000_80E7, 0, n);
      step();
      checks++; if (o_immsel !== 3'b001 || o_opa_sel !== 1'b0) begin errors++; $display("FAIL jalr_exec: got imm=%b a=%b expected 001 0", o_immsel, o_opa_sel); end
      step();
      checks++; if (o_wb_sel !== 2'b10) begin errors++; $display("FAIL jalr_wb_sel: got %b expected 10", o_wb_sel); end
      step();
      checks++; if (o_pc !== 32'h20) begin errors++; $display("FAIL jalr_pc: got %h expected 00000020", o_pc); end
      // ADDI x0,x0,1 never writes
      fetch(32'h0010_0013, 0, n);
      rd_n = 0;
      for (int i = 0; i < 3; i++) begin
         if (o_rd_wren === 1'b1) rd_n++;
         step();
      end
      checks++; if (rd_n !== 0) begin errors++; $display("FAIL addi_x0_wren: got %0d pulses expected 0", rd_n); end
      checks++; if (o_pc !== 32'h24) begin errors++; $display("FAIL addi_x0_pc: got %h expected 00000024", o_pc); end
   endtask

   task automatic test_pc_wrap();
      int n;
      i_alu_res = 32'hFFFF_FFFC;
      fetch(32'h0080_00EF, 0, n);
      step(); step(); step();
      checks++; if (o_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup_pc: got %h expected fffffffc", o_pc); end
      fetch(32'h0050_0093, 0, n);
      step(); step(); step();
      checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected 00000000", o_pc); end
   endtask

   task automatic test_formats();
      logic [31:0] tbl_inst [4];
      logic [2:0]  tbl_imm [4];
      logic        tbl_opa [4];
      logic        tbl_opb [4];
      int n;
      logic [31:0] pc_exp;
      tbl_inst[0] = 32'h1234_50B7; tbl_imm[0] = 3'b101; tbl_opa[0] = 1'b0; tbl_opb[0] = 1'b1;  // LUI
      tbl_inst[1] = 32'h0000_0097; tbl_imm[1] = 3'b101; tbl_opa[1] = 1'b1; tbl_opb[1] = 1'b1;  // AUIPC
      tbl_inst[2] = 32'h0020_81B3; tbl_imm[2] = 3'b000; tbl_opa[2] = 1'b0; tbl_opb[2] = 1'b0;  // ADD
      tbl_inst[3] = 32'h4020_81B3; tbl_imm[3] = 3'b000; tbl_opa[3] = 1'b0; tbl_opb[3] = 1'b0;  // SUB
      pc_exp = o_pc;
      for (int i = 0; i < 4; i++) begin
         fetch(tbl_inst[i], 0, n);
         step();
         checks++; if (o_immsel !== tbl_imm[i] || o_opa_sel !== tbl_opa[i] || o_opb_sel !== tbl_opb[i]) begin errors++; $display("FAIL fmt_%0d_fields: got imm=%b a=%b b=%b expected %b %b %b", i, o_immsel, o_opa_sel, o_opb_sel, tbl_imm[i], tbl_opa[i], tbl_opb[i]); end
         step(); step();
         pc_exp = pc_exp + 32'd4;
         checks++; if (o_pc !== pc_exp) begin errors++; $display("FAIL fmt_%0d_pc: got %h expected %h", i, o_pc, pc_exp); end
      end
   endtask

   task automatic test_illegal();
      int n, bad;
      fetch(32'hFFFF_FFFF, 0, n);
      checks++; if (o_illegal !== 1'b0) begin errors++; $display("FAIL ill_decode_flag: got %b expected 0", o_illegal); end
      step();
      checks++; if (o_illegal !== 1'b1 || o_imem_req !== 1'b0) begin errors++; $display("FAIL ill_trap: got ill=%b req=%b expected 1 0", o_illegal, o_imem_req); end
      i_imem_ack = 1'b1; i_dmem_ack = 1'b1;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (o_imem_req !== 1'b0 || o_dmem_req !== 1'b0 || o_rd_wren !== 1'b0 || o_illegal !== 1'b1) bad++;
         step();
      end
      i_imem_ack = 1'b0; i_dmem_ack = 1'b0;
      checks++; if (bad !== 0) begin errors++; $display("FAIL ill_held: got %0d bad cycles expected 0", bad); end
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      #1;
      checks++; if (o_pc !== 32'h0 || o_imem_req !== 1'b1 || o_illegal !== 1'b0) begin errors++; $display("FAIL ill_recover: got pc=%h req=%b ill=%b expected 00000000 1 0", o_pc, o_imem_req, o_illegal); end
      // BRANCH with funct3=010 is reserved
      fetch(32'h0000_2463, 0, n);
      step();
      checks++; if (o_illegal !== 1'b1 || o_imem_req !== 1'b0) begin errors++; $display("FAIL br_f3_trap: got ill=%b req=%b expected 1 0", o_illegal, o_imem_req); end
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      #1;
   endtask

   task automatic test_reset_mid_mem();
      int n;
      fetch(32'h0000_2103, 0, n);
      step(); step(); step();
      checks++; if (o_dmem_req !== 1'b1) begin errors++; $display("FAIL midmem_waiting: got %b expected 1", o_dmem_req); end
      i_rst = 1'b1;
      #1;
      checks++; if (o_dmem_req !== 1'b0) begin errors++; $display("FAIL midmem_req_in_rst: got %b expected 0", o_dmem_req); end
      step();
      i_rst = 1'b0;
      #1;
      checks++; if (o_imem_req !== 1'b1 || o_dmem_req !== 1'b0 || o_pc !== 32'h0 || o_inst !== 32'h0000_0013) begin errors++; $display("FAIL midmem_recover: got req=%b dreq=%b pc=%h ir=%h expected 1 0 00000000 00000013", o_imem_req, o_dmem_req, o_pc, o_inst); end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_branches();
      test_load_store();
      test_jumps();
      test_pc_wrap();
      test_formats();
      test_illegal();
      test_reset_mid_mem();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
